hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Issue-side hazard scoreboard for the 5-stage pipeline; it produces the stall that the forwarding muxes cannot cover. It sits at the ID/EX boundary. It records, per architectural register, how many cycles remain until an in-flight producer's result reaches a forwardable pipeline point. It stalls the decode-stage instruction on RAW hazards (load-use, multi-cycle ops) and on WAW ordering hazards, so that everything it lets issue can be satisfied by the EX/MEM and MEM/WB forwarding paths.

## Interface
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- LAT_W, 3, width of the latency field and of the per-register countdown.

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds an instruction requesting issue
- id_rs  in  5  source A register index
- id_rt  in  5  source B register index
- id_rs_used  in  1  source A is actually read
- id_rt_used  in  1  source B is actually read
- id_rd  in  5  destination register index
- id_regwrite  in  1  instruction writes id_rd
- id_latency  in  LAT_W  extra cycles before the result becomes forwardable (0 = ALU, 1 = load, >1 = multi-cycle)
- flush  in  1  squash the decode-stage instruction this cycle
- stall  out  1  hold the PC and IF/ID, and insert a bubble into ID/EX
- issue  out  1  the instruction advances into EX this cycle
- busy  out  1  at least one countdown is nonzero
- stall_count  out  32  saturating stall-cycle count (present only with SCOREBOARD_STATS_EN)

## Operation
- State: cnt[r], LAT_W bits, for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- raw = (id_rs_used && id_rs!=0 && cnt[id_rs]!=0) || (id_rt_used && id_rt!=0 && cnt[id_rt]!=0).
- waw = id_regwrite && id_rd!=0 && cnt[id_rd] > id_latency.
- stall = id_valid && !flush && (raw || waw). This is combinational from current state.
- issue = id_valid && !flush && !stall.
- Each clock, every nonzero cnt decrements by 1. A counter at 0 stays at 0.
- Allocation: on issue with id_regwrite, id_rd!=0 and id_latency!=0, cnt[id_rd] <= id_latency. Allocation overrides the decrement for that entry.
- Writers with id_latency==0 allocate nothing, because EX/MEM forwarding covers them.
- Writes to id_rd==0 never allocate.
- flush has priority over everything: no stall, no issue, no allocation. Counters keep decrementing.
- busy = OR of all cnt[r]!=0.

## Timing
- Reset (async assert, synchronous-release semantics handled upstream): all cnt = 0; stall = 0; busy = 0; stall_count = 0. issue follows id_valid && !flush from the first cycle.
- Producer with latency N issued in cycle t: a dependent consumer presented at t+1 stalls for cycles t+1..t+N and issues at t+N+1.
- Load (N=1): exactly one bubble on back-to-back use.
- A consumer of a register whose countdown reaches 0 in the current cycle is not stalled in that cycle. The check uses the registered value only.
- An instruction that both reads and writes the same pending register is stalled by raw. waw is evaluated independently.
- rst_n asserted mid-countdown clears every entry immediately. The first instruction after release sees no hazard.
- No wrap-around: id_latency is bounded by 2^LAT_W-1, and counters only count down.

## Configuration
- SCOREBOARD_STATS_EN defined: a 32-bit stall_count register increments on every cycle where stall==1 and saturates at 0xFFFFFFFF. It is reset to 0 by rst_n.
- SCOREBOARD_STATS_EN undefined: the stall_count port and its register are absent. All other behaviour is identical.

## Structure
- Shared pipeline package holds:
  - REG_IDX_W = 5
  - the reg_idx_t typedef
  - LAT_W default
  - latency constants LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 3; decode uses the same constants.
- One sub-module, scoreboard_entry, instantiated NUM_REGS-1 times. Each instance holds:
  - inputs: a load strobe and load value
  - the countdown register
  - a nonzero flag output
- The top level does the index decode, the hazard OR-reduction and the statistics counter.

## Test plan
- Reset, then id_valid=1, rs=3, rt=4, no prior writers -> stall=0, issue=1, busy=0.
- Load to r5 (latency 1) issued; next cycle consumer with rs=5 -> stall=1 for one cycle, issue=1 on the second cycle.
- Multiply to r7 (latency 3); consumer rt=7 back-to-back -> stall for exactly 3 cycles, then issue. A consumer with rt_used=0 and rt=7 -> no stall.
- Writer to r0 with latency 3, then a consumer reading r0 -> no stall, busy=0.
- WAW: r4 issued with latency 3; next instruction writes r4 with latency 0 -> 3 stall cycles. The same pair with second latency 3 -> no stall, and cnt[4] reloads to 3.
- r9 latency 3 pending, then rst_n pulsed low mid-count -> busy=0 immediately and the consumer of r9 issues. flush with a pending hazard -> stall=0, issue=0, no allocation. With SCOREBOARD_STATS_EN defined, stall_count equals the total number of stalled cycles.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the issue-side hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_IDX_W        = 5;
    localparam int unsigned NUM_REGS_DEFAULT = 32;
    localparam int unsigned LAT_W_DEFAULT    = 3;

    typedef logic [REG_IDX_W-1:0]     reg_idx_t;
    typedef logic [LAT_W_DEFAULT-1:0] lat_t;

    // Extra cycles until a producer's result reaches a forwarding point.
    localparam lat_t LAT_ALU  = lat_t'(0);
    localparam lat_t LAT_LOAD = lat_t'(1);
    localparam lat_t LAT_MUL  = lat_t'(3);

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard request/response bundle.
// stall_count exists only when SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
    parameter int unsigned LAT_W = hazard_scoreboard_pkg::LAT_W_DEFAULT
);
    logic                            id_valid;
    hazard_scoreboard_pkg::reg_idx_t id_rs;
    hazard_scoreboard_pkg::reg_idx_t id_rt;
    logic                            id_rs_used;
    logic                            id_rt_used;
    hazard_scoreboard_pkg::reg_idx_t id_rd;
    logic                            id_regwrite;
    logic [LAT_W-1:0]                id_latency;
    logic                            flush;
    logic                            stall;
    logic                            issue;
    logic                            busy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]                     stall_count;
`endif

    // Decode side: presents the instruction, receives the stall decision.
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output id_rd, id_regwrite, id_latency, flush,
`ifdef SCOREBOARD_STATS_EN
        input  stall_count,
`endif
        input  stall, issue, busy
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  id_rd, id_regwrite, id_latency, flush,
`ifdef SCOREBOARD_STATS_EN
        output stall_count,
`endif
        output stall, issue, busy
    );

endinterface

// File: rtl/scoreboard_entry.sv
// One register's countdown until its pending result becomes forwardable.
module scoreboard_entry #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt,
    output logic             nonzero
);

    // Reload on allocation, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard at the ID/EX boundary: stalls decode on RAW
// and WAW hazards that the EX/MEM and MEM/WB forwarding paths cannot cover.
// Optional feature macro: SCOREBOARD_STATS_EN (saturating stall_count).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned LAT_W    = LAT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  sb
);

    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    logic                raw;
    logic                waw;
    logic                stall_c;
    logic                issue_c;
    logic                alloc_en;

    // Register 0 is hardwired zero and never has a pending producer.
    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    // One countdown per architectural register, loaded by destination decode.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (alloc_en && (sb.id_rd == reg_idx_t'(r))),
            .load_val (sb.id_latency),
            .cnt      (cnt[r]),
            .nonzero  (nz[r])
        );
    end

    // Hazard detection from the registered countdowns only.
    always_comb begin
        raw      = 1'b0;
        waw      = 1'b0;
        raw      = (sb.id_rs_used && (sb.id_rs != '0) && (cnt[sb.id_rs] != '0)) ||
                   (sb.id_rt_used && (sb.id_rt != '0) && (cnt[sb.id_rt] != '0));
        waw      = sb.id_regwrite && (sb.id_rd != '0) && (cnt[sb.id_rd] > sb.id_latency);
        stall_c  = sb.id_valid && !sb.flush && (raw || waw);
        issue_c  = sb.id_valid && !sb.flush && !stall_c;
        // ALU results are covered by EX/MEM forwarding, so they need no entry.
        alloc_en = issue_c && sb.id_regwrite && (sb.id_rd != '0) &&
                   (sb.id_latency != LAT_W'(LAT_ALU));
    end

    assign sb.stall = stall_c;
    assign sb.issue = issue_c;
    assign sb.busy  = |nz;

`ifdef SCOREBOARD_STATS_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.stall_count <= '0;
        end else if (stall_c && (sb.stall_count != '1)) begin
            sb.stall_count <= sb.stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// randomized traffic against a ready-time reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if sb_if ();

    hazard_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    int     checks;
    int     failures;
    longint cyc;
    longint ready [32];   // cycle at which register r becomes forwardable
    int     exp_stalls;

    // Cycles still to wait for register r in the current cycle.
    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (ready[r] > cyc) ? int'(ready[r] - cyc) : 0;
    endfunction

    function automatic bit m_stall();
        bit raw;
        bit waw;
        raw = (sb_if.id_rs_used && rem(int'(sb_if.id_rs)) != 0) ||
              (sb_if.id_rt_used && rem(int'(sb_if.id_rt)) != 0);
        waw = sb_if.id_regwrite && (rem(int'(sb_if.id_rd)) > int'(sb_if.id_latency));
        return sb_if.id_valid && !sb_if.flush && (raw || waw);
    endfunction

    function automatic bit m_issue();
        return sb_if.id_valid && !sb_if.flush && !m_stall();
    endfunction

    function automatic bit m_busy();
        for (int r = 1; r < 32; r++) if (rem(r) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        exp_stalls = 0;
    endtask

    // Apply one decode-stage request mid-cycle, then let outputs settle.
    task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                         input int rd, input bit rw, input int lat, input bit fl);
        @(negedge clk);
        sb_if.id_valid    = v;
        sb_if.id_rs       = reg_idx_t'(rs);
        sb_if.id_rt       = reg_idx_t'(rt);
        sb_if.id_rs_used  = rsu;
        sb_if.id_rt_used  = rtu;
        sb_if.id_rd       = reg_idx_t'(rd);
        sb_if.id_regwrite = rw;
        sb_if.id_latency  = 3'(lat);
        sb_if.flush       = fl;
        #1;
    endtask

    // Advance the model across the next rising edge.
    task automatic tick();
        bit st;
        bit is;
        int rd;
        int lat;
        st  = m_stall();
        is  = m_issue();
        rd  = int'(sb_if.id_rd);
        lat = int'(sb_if.id_latency);
        @(posedge clk);
        if (st) exp_stalls++;
        if (is && sb_if.id_regwrite && rd != 0 && lat != 0) ready[rd] = cyc + 1 + lat;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        drive(1, 3, 4, 1, 1, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", sb_if.stall); end
        checks++;
        if (sb_if.issue !== 1'b1) begin failures++; $display("FAIL reset_issue got=%b exp=1", sb_if.issue); end
        checks++;
        if (sb_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", sb_if.busy); end
`ifdef SCOREBOARD_STATS_EN
        checks++;
        if (sb_if.stall_count !== 32'd0) begin failures++; $display("FAIL reset_stall_count got=%0d exp=0", sb_if.stall_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_hazard();
        drive(1, 3, 4, 1, 1, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1 || sb_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL no_hazard got stall=%b issue=%b busy=%b exp 0/1/0", sb_if.stall, sb_if.issue, sb_if.busy);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0, 5, 1, int'(LAT_LOAD), 0);
        checks++;
        if (sb_if.issue !== 1'b1) begin failures++; $display("FAIL load_issue got=%b exp=1", sb_if.issue); end
        tick();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b1 || sb_if.issue !== 1'b0) begin
            failures++; $display("FAIL load_use_bubble got stall=%b issue=%b exp 1/0", sb_if.stall, sb_if.issue);
        end
        tick();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1) begin
            failures++; $display("FAIL load_use_release got stall=%b issue=%b exp 0/1", sb_if.stall, sb_if.issue);
        end
        tick();
    endtask

    task automatic test_mul();
        int stalls;
        drive(1, 0, 0, 0, 0, 7, 1, int'(LAT_MUL), 0);
        tick();
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 7, 0, 1, 0, 0, 0, 0);
            if (sb_if.stall === 1'b1) stalls++;
            tick();
            if (sb_if.issue === 1'b1) break;
        end
        checks++;
        if (stalls != 3) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=3", stalls); end
        checks++;
        if (sb_if.issue !== 1'b1) begin failures++; $display("FAIL mul_consumer_issue got=%b exp=1", sb_if.issue); end
        drive(1, 0, 0, 0, 0, 7, 1, int'(LAT_MUL), 0);
        tick();
        drive(1, 0, 7, 0, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0 || sb_if.busy !== 1'b1) begin
            failures++; $display("FAIL rt_unused got stall=%b busy=%b exp 0/1", sb_if.stall, sb_if.busy);
        end
        tick();
        drain(4);
    endtask

    task automatic test_r0();
        drive(1, 0, 0, 0, 0, 0, 1, 3, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0 || sb_if.busy !== 1'b0) begin
            failures++; $display("FAIL r0_writer got stall=%b busy=%b exp 0/0", sb_if.stall, sb_if.busy);
        end
        tick();
    endtask

    task automatic test_waw();
        int stalls;
        drive(1, 0, 0, 0, 0, 4, 1, 3, 0);
        tick();
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
            if (sb_if.stall === 1'b1) stalls++;
            tick();
            if (sb_if.issue === 1'b1) break;
        end
        checks++;
        if (stalls != 3) begin failures++; $display("FAIL waw_lat0_stalls got=%0d exp=3", stalls); end
        drain(2);
        drive(1, 0, 0, 0, 0, 4, 1, 3, 0);
        tick();
        drive(1, 0, 0, 0, 0, 4, 1, 3, 0);
        checks++;
        if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL waw_same_lat got=%b exp=0", sb_if.stall); end
        tick();
        // The reload restarts at 3: a reader must now wait three full cycles.
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4, 0, 1, 0, 0, 0, 0, 0);
            if (sb_if.stall === 1'b1) stalls++;
            tick();
            if (sb_if.issue === 1'b1) break;
        end
        checks++;
        if (stalls != 3) begin failures++; $display("FAIL waw_reload_stalls got=%0d exp=3", stalls); end
        drain(2);
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 9, 1, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b exp=1", sb_if.busy); end
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (sb_if.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy_after got=%b exp=0", sb_if.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1) begin
            failures++; $display("FAIL midreset_consumer got stall=%b issue=%b exp 0/1", sb_if.stall, sb_if.issue);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 0, 10, 1, 3, 0);
        tick();
        drive(1, 10, 0, 1, 0, 11, 1, 3, 1);
        checks++;
        if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b0) begin
            failures++; $display("FAIL flush_outputs got stall=%b issue=%b exp 0/0", sb_if.stall, sb_if.issue);
        end
        tick();
        drive(1, 11, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL flush_no_alloc got=%b exp=0", sb_if.stall); end
        tick();
        drain(4);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
                  1'($urandom), 1'($urandom), $urandom_range(7, 0), 1'($urandom),
                  $urandom_range(7, 0), $urandom_range(7, 0) == 0);
            checks++;
            if (sb_if.stall !== m_stall() || sb_if.issue !== m_issue() || sb_if.busy !== m_busy()) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d got stall=%b issue=%b busy=%b exp %b/%b/%b",
                             i, sb_if.stall, sb_if.issue, sb_if.busy, m_stall(), m_issue(), m_busy());
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_stats();
`ifdef SCOREBOARD_STATS_EN
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (sb_if.stall_count !== 32'(exp_stalls)) begin
            failures++; $display("FAIL stall_count got=%0d exp=%0d", sb_if.stall_count, exp_stalls);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        model_clear();
        test_reset();
        test_no_hazard();
        test_load_use();
        test_mul();
        test_r0();
        test_waw();
        test_reset_mid();
        test_flush();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
